// File: rtl/clarke_pipe_if.sv
// clarke_pipe_if: valid/ready input and output beat bundle for the Clarke pipeline.
interface clarke_pipe_if #(
  parameter int D_WIDTH = 18,
  parameter int TAG_W = 2
);
  logic in_valid;
  logic in_ready;
  logic in_mode;
  logic [TAG_W-1:0] in_tag;
  logic signed [D_WIDTH-1:0] in_x;
  logic signed [D_WIDTH-1:0] in_y;
  logic out_valid;
  logic out_ready;
  logic out_mode;
  logic [TAG_W-1:0] out_tag;
  logic signed [D_WIDTH-1:0] out_0;
  logic signed [D_WIDTH-1:0] out_1;
  logic signed [D_WIDTH-1:0] out_2;
  logic out_sat;
  modport master (
    output in_valid, in_mode, in_tag, in_x, in_y, out_ready,
    input in_ready, out_valid, out_mode, out_tag, out_0, out_1, out_2, out_sat
  );
  modport slave (
    input in_valid, in_mode, in_tag, in_x, in_y, out_ready,
    output in_ready, out_valid, out_mode, out_tag, out_0, out_1, out_2, out_sat
  );
endinterface

// File: rtl/clarke_pipe.sv
// clarke_pipe: 3-stage forward/inverse Clarke transform with valid/ready, rounding and saturation.
module clarke_pipe #(
  parameter int D_WIDTH = 18,
  parameter int Q_BITS = 15,
  parameter int TAG_W = 2
) (
  input logic clk,
  input logic rstb,
  clarke_pipe_if.slave bus
);
  localparam int W = (D_WIDTH + Q_BITS + 6 > 2 * D_WIDTH + 2) ? D_WIDTH + Q_BITS + 6 : 2 * D_WIDTH + 2;
  function automatic longint unsigned isqrt(input longint unsigned n);
    longint unsigned r = 0;
    for (int i = 31; i >= 0; i--)
      if (((r | (64'd1 << i)) * (r | (64'd1 << i))) <= n) r = r | (64'd1 << i);
    return r;
  endfunction
  // round(sqrt(m)) == (isqrt(4m) + 1) >> 1, so both constants stay exact integers
  localparam longint unsigned K1U = (isqrt((64'd1 << (2 * Q_BITS + 2)) / 3) + 1) >> 1;
  localparam longint unsigned K2U = (isqrt(64'd3 << (2 * Q_BITS + 2)) + 1) >> 1;
  localparam logic signed [W-1:0] K1 = W'(K1U);
  localparam logic signed [W-1:0] K2 = W'(K2U);
  localparam logic signed [W-1:0] MAXV = W'((64'sd1 <<< (D_WIDTH - 1)) - 64'sd1);
  localparam logic signed [W-1:0] MINV = ~MAXV;
  localparam logic signed [W-1:0] HF = W'(1) << (Q_BITS - 1);
  localparam logic signed [W-1:0] HI = W'(1) << Q_BITS;
  function automatic logic signed [D_WIDTH-1:0] clamp(input logic signed [W-1:0] v);
    return v > MAXV ? D_WIDTH'(MAXV) : v < MINV ? D_WIDTH'(MINV) : D_WIDTH'(v);
  endfunction
  logic adv;
  logic v1, v2, v3, md1, md2, md3, st3;
  logic [TAG_W-1:0] t1, t2, t3;
  logic signed [D_WIDTH-1:0] x1, y1, x2, o0, o1, o2;
  logic signed [W-1:0] a1, r1, r2;
  logic signed [W-1:0] xe, ye, ye1, a1_n, mb, r1_n, r2_n, q_b, q_c;
  logic sat_b, sat_c;
  always_comb begin
    adv = bus.out_ready | ~v3;
    xe = W'(bus.in_x);
    ye = W'(bus.in_y);
    a1_n = bus.in_mode ? -(xe <<< Q_BITS) : xe + (ye <<< 1);
    ye1 = W'(y1);
    mb = K2 * ye1;
    r1_n = md1 ? a1 + mb : a1 * K1;
    r2_n = a1 - mb;
    q_b = md2 ? (r1 + HI) >>> (Q_BITS + 1) : (r1 + HF) >>> Q_BITS;
    q_c = (r2 + HI) >>> (Q_BITS + 1);
    sat_b = (q_b > MAXV) || (q_b < MINV);
    sat_c = md2 && ((q_c > MAXV) || (q_c < MINV));
  end
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      {v1, v2, v3, md1, md2, md3, st3} <= '0;
      {t1, t2, t3} <= '0;
      {x1, y1, x2, o0, o1, o2} <= '0;
      {a1, r1, r2} <= '0;
    end else if (adv) begin
      v1 <= bus.in_valid;
      md1 <= bus.in_mode;
      t1 <= bus.in_tag;
      x1 <= bus.in_x;
      y1 <= bus.in_y;
      a1 <= a1_n;
      v2 <= v1;
      md2 <= md1;
      t2 <= t1;
      x2 <= x1;
      r1 <= r1_n;
      r2 <= r2_n;
      v3 <= v2;
      md3 <= md2;
      t3 <= t2;
      o0 <= x2;
      o1 <= clamp(q_b);
      o2 <= md2 ? clamp(q_c) : '0;
      st3 <= v2 & (sat_b | sat_c);
    end
  end
  assign bus.in_ready = adv;
  assign bus.out_valid = v3;
  assign bus.out_mode = md3;
  assign bus.out_tag = t3;
  assign bus.out_0 = o0;
  assign bus.out_1 = o1;
  assign bus.out_2 = o2;
  assign bus.out_sat = st3;
endmodule

// File: tb/tb_clarke_pipe.sv
// tb_clarke_pipe: directed and randomized checks of clarke_pipe against an arithmetic reference model.
module tb_clarke_pipe;
  localparam int D = 18;
  localparam int Q = 15;
  localparam int T = 2;
  localparam longint K1 = 18919;
  localparam longint K2 = 56756;
  logic clk = 0;
  logic rstb = 0;
  always #5 clk = ~clk;
  clarke_pipe_if #(.D_WIDTH(D), .TAG_W(T)) bus ();
  clarke_pipe #(.D_WIDTH(D), .Q_BITS(Q), .TAG_W(T)) dut (.clk(clk), .rstb(rstb), .bus(bus));
  int checks = 0;
  int errors = 0;
  typedef struct {
    bit mode;
    bit [1:0] tag;
    longint o0, o1, o2;
    bit sat;
  } beat_t;
  beat_t sb[$];

  function automatic longint fdiv(longint n, longint d);
    longint q = n / d;
    if ((n % d) != 0 && n < 0) q--;
    return q;
  endfunction

  // value n / 2^s rounded half up: floor(n/2^s + 1/2)
  function automatic longint rhu(longint n, int s);
    return fdiv(2 * n + (longint'(1) << s), longint'(1) << (s + 1));
  endfunction

  function automatic beat_t model(bit m, bit [1:0] t, longint x, longint y);
    beat_t b;
    longint hi = (longint'(1) << (D - 1)) - 1;
    longint lo = -(longint'(1) << (D - 1));
    longint u, w;
    b.mode = m;
    b.tag = t;
    b.o0 = x;
    if (!m) begin
      u = rhu((x + 2 * y) * K1, Q);
      w = 0;
    end else begin
      u = rhu(-x * (longint'(1) << Q) + K2 * y, Q + 1);
      w = rhu(-x * (longint'(1) << Q) - K2 * y, Q + 1);
    end
    b.sat = (u > hi) || (u < lo) || (w > hi) || (w < lo);
    b.o1 = u > hi ? hi : (u < lo ? lo : u);
    b.o2 = w > hi ? hi : (w < lo ? lo : w);
    return b;
  endfunction

  function automatic longint rnd_val();
    logic signed [D-1:0] v;
    int k = int'($urandom_range(0, 5));
    v = D'($urandom);
    if (k == 0) return 131071;
    if (k == 1) return -131072;
    return longint'(v);
  endfunction

  function automatic logic [58:0] snap();
    return {bus.out_valid, bus.out_mode, bus.out_tag, bus.out_0, bus.out_1, bus.out_2, bus.out_sat};
  endfunction

  task automatic drive(input bit v, input bit m, input bit [1:0] t, input longint x, input longint y);
    bus.in_valid = v;
    bus.in_mode = m;
    bus.in_tag = t;
    bus.in_x = D'(x);
    bus.in_y = D'(y);
  endtask

  task automatic run_beat(input bit m, input bit [1:0] t, input longint x, input longint y, output int lat);
    @(negedge clk);
    drive(1, m, t, x, y);
    bus.out_ready = 1;
    lat = 0;
    do begin
      @(negedge clk);
      bus.in_valid = 0;
      lat++;
    end while (!bus.out_valid && lat < 10);
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0);
    bus.out_ready = 0;
    rstb = 0;
    repeat (3) @(negedge clk);
    checks++;
    if (snap() !== '0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_hold outputs=%h in_ready=%b expected 0 and 1", snap(), bus.in_ready);
    end
    rstb = 1;
    @(posedge clk);
    #1;
    checks++;
    if (snap() !== '0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release outputs=%h in_ready=%b expected 0 and 1", snap(), bus.in_ready);
    end
  endtask

  task automatic test_directed(input bit m, input longint x, input longint y,
                               input longint e1, input longint e2, input bit es, input bit [1:0] t);
    int lat;
    run_beat(m, t, x, y, lat);
    checks++;
    if (lat !== 3 || bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency got=%0d valid=%b expected 3 and 1", lat, bus.out_valid);
    end
    checks++;
    if (longint'(bus.out_0) !== x || longint'(bus.out_1) !== e1 || longint'(bus.out_2) !== e2 ||
        bus.out_sat !== es || bus.out_mode !== m || bus.out_tag !== t) begin
      errors++;
      $display("FAIL directed m=%0d x=%0d y=%0d got o0=%0d o1=%0d o2=%0d sat=%b mode=%b tag=%0d expected o0=%0d o1=%0d o2=%0d sat=%b",
               m, x, y, bus.out_0, bus.out_1, bus.out_2, bus.out_sat, bus.out_mode, bus.out_tag, x, e1, e2, es);
    end
    @(negedge clk);
  endtask

  task automatic test_forward();
    test_directed(0, 16384, 0, 9460, 0, 0, 1);
    test_directed(0, 32767, 32767, 56755, 0, 0, 2);
  endtask

  task automatic test_saturation();
    test_directed(0, 131071, 131071, 131071, 0, 1, 3);
    test_directed(0, -131072, -131072, -131072, 0, 1, 0);
  endtask

  task automatic test_inverse();
    test_directed(1, 0, 16384, 14189, -14189, 0, 1);
    test_directed(1, 16384, 0, -8192, -8192, 0, 2);
  endtask

  task automatic stream(input int n, input int vpct, input int rpct, input int st_lo, input int st_hi, output int cyc);
    int sent = 0, got = 0;
    bit stalled = 0;
    logic [58:0] held = '0;
    beat_t e;
    longint x, y;
    bit m;
    sb.delete();
    cyc = 0;
    while ((sent < n || sb.size() > 0) && cyc < 20 * n + 50) begin
      @(negedge clk);
      if (stalled) begin
        checks++;
        if (snap() !== held) begin
          errors++;
          $display("FAIL stall_hold got=%h expected=%h", snap(), held);
        end
      end
      x = rnd_val();
      y = rnd_val();
      m = 1'($urandom);
      drive(sent < n && int'($urandom_range(0, 99)) < vpct, m, 2'(sent % 4), x, y);
      bus.out_ready = (cyc >= st_lo && cyc <= st_hi) ? 1'b0 : (int'($urandom_range(0, 99)) < rpct);
      #1;
      checks++;
      if (bus.in_ready !== (bus.out_ready | ~bus.out_valid)) begin
        errors++;
        $display("FAIL in_ready got=%b out_valid=%b out_ready=%b", bus.in_ready, bus.out_valid, bus.out_ready);
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL extra_beat tag=%0d o0=%0d expected no beat", bus.out_tag, bus.out_0);
        end else begin
          e = sb.pop_front();
          got++;
          if (bus.out_mode !== e.mode || bus.out_tag !== e.tag || longint'(bus.out_0) !== e.o0 ||
              longint'(bus.out_1) !== e.o1 || longint'(bus.out_2) !== e.o2 || bus.out_sat !== e.sat) begin
            errors++;
            $display("FAIL beat got m=%b t=%0d o=%0d,%0d,%0d s=%b expected m=%b t=%0d o=%0d,%0d,%0d s=%b",
                     bus.out_mode, bus.out_tag, bus.out_0, bus.out_1, bus.out_2, bus.out_sat,
                     e.mode, e.tag, e.o0, e.o1, e.o2, e.sat);
          end
        end
      end
      stalled = bus.out_valid && !bus.out_ready;
      held = snap();
      if (bus.in_valid && bus.in_ready) begin
        sb.push_back(model(m, 2'(sent % 4), x, y));
        sent++;
      end
      cyc++;
    end
    bus.in_valid = 0;
    bus.out_ready = 1;
    repeat (5) begin
      @(negedge clk);
      if (bus.out_valid) got++;
    end
    checks++;
    if (got !== n || sb.size() !== 0) begin
      errors++;
      $display("FAIL beat_count got=%0d pending=%0d expected %0d and 0", got, sb.size(), n);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    stream(6, 100, 100, 4, 7, cyc);
  endtask

  task automatic test_back_to_back();
    int cyc;
    stream(20, 100, 100, -1, -2, cyc);
    checks++;
    if (cyc !== 23) begin
      errors++;
      $display("FAIL throughput cycles=%0d expected 23", cyc);
    end
  endtask

  task automatic test_random();
    int cyc;
    stream(150, 70, 60, -1, -2, cyc);
  endtask

  task automatic test_reset_midstream();
    int seen = 0;
    bus.out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1, 1'(i), 2'(i), 1000 * (i + 1), 500);
    end
    @(negedge clk);
    bus.in_valid = 0;
    bus.out_ready = 0;
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL midstream_fill out_valid=%b expected 1", bus.out_valid);
    end
    #2;
    rstb = 0;
    #1;
    checks++;
    if (snap() !== '0) begin
      errors++;
      $display("FAIL async_reset outputs=%h expected 0", snap());
    end
    @(negedge clk);
    rstb = 1;
    bus.out_ready = 1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_ready got=%b expected 1", bus.in_ready);
    end
    repeat (8) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL ghost_beats got=%0d expected 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_saturation();
    test_inverse();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
